mux16_select_reg: RTL and testbench

Registered 16-to-1 single-bit multiplexer. It selects one bit of a 16-bit input word by a 4-bit index and presents it on a flopped output one clock later. The datapath is a gate-level tree built from 2:1 and 4:1 mux cells. An optional behavioural reference path cross-checks that tree in hardware. The block is a leaf datapath element, used wherever a bit-select from a 16-bit bus must be timing-clean at the next stage.

---
 rtl/mux16_select_reg.sv | 89 ++++++++
 tb/tb_mux16_select_reg.sv | 106 ++++++++++
 2 files changed

// File: rtl/mux16_select_reg.sv
// rtl/mux16_select_reg.sv - registered 16-to-1 bit select built from a 2:1/4:1 mux-cell tree
//
// Purpose : forwards in[sel] to a flop so the selected bit is timing-clean at
//           the next stage. Latency 1 clock, one selection per cycle, no stall.
// Ports   : clk      - rising-edge clock
//           rst      - synchronous active-high reset, clears out and mismatch
//           in[15:0] - candidate bits, in[i] is candidate i
//           sel[3:0] - unsigned index of the bit to forward
//           out      - registered selected bit
//           mismatch - registered sticky tree-vs-reference error flag
// Config  : MUX16_XCHECK_EN - when defined, a behavioural in[sel] reference is
//           compared against the tree each clock and any difference sets the
//           sticky mismatch flop. When undefined, mismatch is constant 0.

module mux16_mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = (a & ~s) | (b & s);
endmodule

module mux16_mux4 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);
    logic lo;
    logic hi;

    mux16_mux2 u_lo  (.a(d[0]), .b(d[1]), .s(s[0]), .y(lo));
    mux16_mux2 u_hi  (.a(d[2]), .b(d[3]), .s(s[0]), .y(hi));
    mux16_mux2 u_out (.a(lo),   .b(hi),   .s(s[1]), .y(y));
endmodule

module mux16_select_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out,
    output logic        mismatch
);
    logic [3:0] lvl1;
    logic       tree_y;

    // Level 1: cell k reduces in[4k+3:4k] using the low select bits.
    for (genvar k = 0; k < 4; k++) begin : g_lvl1
        mux16_mux4 u_cell (
            .d (in[4*k +: 4]),
            .s (sel[1:0]),
            .y (lvl1[k])
        );
    end

    // Level 2: the high select bits pick which nibble's result survives.
    mux16_mux4 u_lvl2 (
        .d (lvl1),
        .s (sel[3:2]),
        .y (tree_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= tree_y;
        end
    end

`ifdef MUX16_XCHECK_EN
    logic ref_y;

    assign ref_y = in[sel];

    // Sticky: once the tree disagrees with the reference, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (ref_y != tree_y) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mux16_select_reg.sv
// tb/tb_mux16_select_reg.sv - directed self-checking bench for mux16_select_reg

module tb_mux16_select_reg;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [3:0]  sel;
    logic        out;
    logic        mismatch;

    int checks   = 0;
    int failures = 0;

    mux16_select_reg dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .sel      (sel),
        .out      (out),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [15:0] d, input logic [3:0] s);
        rst = r;
        in  = d;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] b2b_in  [6] = '{16'h8000, 16'h0000, 16'h0001, 16'hFFFE, 16'h1234, 16'h5A5A};
    logic [3:0]  b2b_sel [6] = '{4'd15,    4'd15,    4'd0,     4'd0,     4'd4,     4'd7};
    logic        b2b_exp [6] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};

    initial begin
        rst = 1'b1;
        in  = 16'hFFFF;
        sel = 4'd5;
        #2;

        // Reset held two cycles with data that would otherwise give 1.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'hFFFF, 4'd5);
            check("reset_out", out, 1'b0);
            check("reset_mismatch", mismatch, 1'b0);
        end

        // Alternating pattern: odd indices are 1.
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 16'hAAAA, 4'(s));
            check($sformatf("aaaa_sel%0d", s), out, 1'(s % 2));
            check("aaaa_mismatch", mismatch, 1'b0);
        end

        // Walking one: 1 only where sel hits the set bit.
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                step(1'b0, 16'h0001 << k, 4'(s));
                check($sformatf("walk_k%0d_sel%0d", k, s), out, (s == k) ? 1'b1 : 1'b0);
            end
        end
        check("walk_mismatch", mismatch, 1'b0);

        // Back-to-back changes of both in and sel.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, b2b_in[i], b2b_sel[i]);
            check($sformatf("b2b_%0d", i), out, b2b_exp[i]);
        end

        // Reset in the middle of the alternating sweep.
        for (int s = 0; s < 7; s++) begin
            step(1'b0, 16'hAAAA, 4'(s));
            check($sformatf("mid_pre_sel%0d", s), out, 1'(s % 2));
        end
        step(1'b1, 16'hAAAA, 4'd7);
        check("mid_reset_out", out, 1'b0);
        check("mid_reset_mismatch", mismatch, 1'b0);
        step(1'b0, 16'hAAAA, 4'd8);
        check("mid_resume_sel8", out, 1'b0);
        step(1'b0, 16'hAAAA, 4'd9);
        check("mid_resume_sel9", out, 1'b1);
        step(1'b0, 16'hAAAA, 4'd10);
        check("mid_resume_sel10", out, 1'b0);
        step(1'b0, 16'hAAAA, 4'd15);
        check("mid_resume_sel15", out, 1'b1);
        check("final_mismatch", mismatch, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
